// File: rtl/idex_pipe_reg.sv
// ID/EX pipeline register for the pipelined MIPS core. It provides valid tracking, a downstream
// hold, a multi-cycle flush shadow after taken branches/jumps, and load-use bubble insertion.
module idex_pipe_reg #(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5,
  parameter int FNCT_W      = 6,
  parameter int WB_W        = 2,
  parameter int MEM_W       = 2,
  parameter int EX_W        = 4,
  parameter int MEM_RD_BIT  = 1,
  parameter int FLUSH_DEPTH = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic [WB_W-1:0]   wb_in,
  input  logic [MEM_W-1:0]  mem_in,
  input  logic [EX_W-1:0]   ex_in,
  input  logic [FNCT_W-1:0] fnct,
  input  logic [DATA_W-1:0] imm,
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [REG_AW-1:0] rt_addr,
  input  logic [REG_AW-1:0] rd_addr,
  input  logic [DATA_W-1:0] opA,
  input  logic [DATA_W-1:0] opB,
  output logic [WB_W-1:0]   WB,
  output logic [MEM_W-1:0]  MEM,
  output logic [EX_W-1:0]   EX,
  output logic [FNCT_W-1:0] fnct_ex,
  output logic [DATA_W-1:0] imm_ex,
  output logic [REG_AW-1:0] rd_addr_ex,
  output logic [REG_AW-1:0] rt_addr_ex,
  output logic [DATA_W-1:0] opA_ex,
  output logic [DATA_W-1:0] opB_ex,
  output logic              valid_ex,
  output logic              hazard_stall,
  output logic              flush_busy
);

  localparam int CNT_W = $clog2(FLUSH_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(FLUSH_DEPTH - 1);

  logic [WB_W-1:0]   wb_r;
  logic [MEM_W-1:0]  mem_r;
  logic [EX_W-1:0]   ex_r;
  logic [FNCT_W-1:0] fnct_r;
  logic [DATA_W-1:0] imm_r;
  logic [REG_AW-1:0] rd_r;
  logic [REG_AW-1:0] rt_r;
  logic [DATA_W-1:0] opa_r;
  logic [DATA_W-1:0] opb_r;
  logic              valid_r;
  logic [CNT_W-1:0]  cnt_r;

  logic              busy_s;
  logic              hazard_s;
  logic              bubble_s;
  logic              load_s;
  logic [CNT_W-1:0]  cnt_nxt_s;

  assign busy_s = (cnt_r != '0);

  // Load-use detection against the load currently sitting in EX; masked during flush shadow.
  always_comb begin
    hazard_s = 1'b0;
    if (!flush && !busy_s && valid_r && mem_r[MEM_RD_BIT] && in_valid &&
        (rt_r != '0) && ((rt_r == rs_addr) || (rt_r == rt_addr))) begin
      hazard_s = 1'b1;
    end else begin
      hazard_s = 1'b0;
    end
  end

  // Per-edge action select: flush > flush shadow > stall > hazard > load.
  always_comb begin
    bubble_s  = 1'b0;
    load_s    = 1'b0;
    cnt_nxt_s = cnt_r;
    if (flush) begin
      bubble_s  = 1'b1;
      cnt_nxt_s = CNT_RELOAD;
    end else if (busy_s) begin
      if (!stall) begin
        bubble_s  = 1'b1;
        cnt_nxt_s = cnt_r - CNT_W'(1);
      end else begin
        cnt_nxt_s = cnt_r;
      end
    end else if (stall) begin
      cnt_nxt_s = cnt_r;
    end else if (hazard_s) begin
      bubble_s = 1'b1;
    end else begin
      load_s = 1'b1;
    end
  end

  // Flush shadow counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

  // Pipeline fields: a bubble clears everything; an invalid ID slot carries no control.
  always_ff @(posedge clk) begin
    if (rst || bubble_s) begin
      wb_r    <= '0;
      mem_r   <= '0;
      ex_r    <= '0;
      fnct_r  <= '0;
      imm_r   <= '0;
      rd_r    <= '0;
      rt_r    <= '0;
      opa_r   <= '0;
      opb_r   <= '0;
      valid_r <= 1'b0;
    end else if (load_s) begin
      wb_r    <= in_valid ? wb_in  : '0;
      mem_r   <= in_valid ? mem_in : '0;
      ex_r    <= in_valid ? ex_in  : '0;
      fnct_r  <= fnct;
      imm_r   <= imm;
      rd_r    <= rd_addr;
      rt_r    <= rt_addr;
      opa_r   <= opA;
      opb_r   <= opB;
      valid_r <= in_valid;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign WB           = wb_r;
  assign MEM          = mem_r;
  assign EX           = ex_r;
  assign fnct_ex      = fnct_r;
  assign imm_ex       = imm_r;
  assign rd_addr_ex   = rd_r;
  assign rt_addr_ex   = rt_r;
  assign opA_ex       = opa_r;
  assign opB_ex       = opb_r;
  assign valid_ex     = valid_r;
  assign hazard_stall = hazard_s;
  assign flush_busy   = busy_s;

endmodule

// File: tb/tb_idex_pipe_reg.sv
// Randomized and directed bench for idex_pipe_reg; three instances (FLUSH_DEPTH 1..3) share
// the stimulus and each is compared against a stage-level reference model.
module tb_idex_pipe_reg;

  typedef struct packed {
    logic [1:0]  wb;
    logic [1:0]  mem;
    logic [3:0]  ex;
    logic [5:0]  fnct;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rt;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        valid;
  } stage_t;

  logic        clk = 1'b0;
  logic        rst, in_valid, stall, flush;
  logic [1:0]  wb_in, mem_in;
  logic [3:0]  ex_in;
  logic [5:0]  fnct;
  logic [31:0] imm, opA, opB;
  logic [4:0]  rs_addr, rt_addr, rd_addr;

  logic [1:0]  wb_o   [3];
  logic [1:0]  mem_o  [3];
  logic [3:0]  ex_o   [3];
  logic [5:0]  fnct_o [3];
  logic [31:0] imm_o  [3];
  logic [4:0]  rd_o   [3];
  logic [4:0]  rt_o   [3];
  logic [31:0] opa_o  [3];
  logic [31:0] opb_o  [3];
  logic        valid_o[3];
  logic        hz_o   [3];
  logic        fb_o   [3];

  stage_t mdl    [3];
  int     shadow [3];
  int     n_checks = 0;
  int     n_errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    idex_pipe_reg #(.FLUSH_DEPTH(g + 1)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
      .wb_in(wb_in), .mem_in(mem_in), .ex_in(ex_in), .fnct(fnct), .imm(imm),
      .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr), .opA(opA), .opB(opB),
      .WB(wb_o[g]), .MEM(mem_o[g]), .EX(ex_o[g]), .fnct_ex(fnct_o[g]), .imm_ex(imm_o[g]),
      .rd_addr_ex(rd_o[g]), .rt_addr_ex(rt_o[g]), .opA_ex(opa_o[g]), .opB_ex(opb_o[g]),
      .valid_ex(valid_o[g]), .hazard_stall(hz_o[g]), .flush_busy(fb_o[g])
    );
  end

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic stage_t observed(input int k);
    return '{wb_o[k], mem_o[k], ex_o[k], fnct_o[k], imm_o[k], rd_o[k], rt_o[k],
             opa_o[k], opb_o[k], valid_o[k]};
  endfunction

  // Load-use: EX holds a valid load whose destination (nonzero) is read by a valid ID instr.
  function automatic logic model_hazard(input int k);
    if (flush || shadow[k] > 0) return 1'b0;
    return mdl[k].valid && mdl[k].mem[1] && in_valid && (mdl[k].rt != 5'd0) &&
           ((mdl[k].rt == rs_addr) || (mdl[k].rt == rt_addr));
  endfunction

  function automatic void model_edge(input int k, input logic hz);
    stage_t nxt;
    if (rst) begin
      mdl[k] = '0; shadow[k] = 0;
    end else if (flush) begin
      mdl[k] = '0; shadow[k] = k;
    end else if (shadow[k] > 0) begin
      if (!stall) begin mdl[k] = '0; shadow[k] = shadow[k] - 1; end
    end else if (stall) begin
      shadow[k] = 0;
    end else if (hz) begin
      mdl[k] = '0;
    end else begin
      nxt.wb = in_valid ? wb_in : 2'd0;
      nxt.mem = in_valid ? mem_in : 2'd0;
      nxt.ex = in_valid ? ex_in : 4'd0;
      nxt.fnct = fnct; nxt.imm = imm; nxt.rd = rd_addr; nxt.rt = rt_addr;
      nxt.opa = opA; nxt.opb = opB; nxt.valid = in_valid;
      mdl[k] = nxt;
    end
  endfunction

  // Inputs are set after a falling edge; check comb outputs, clock once, check registers.
  task automatic step();
    logic hz[3];
    #2;
    for (int k = 0; k < 3; k++) begin
      hz[k] = model_hazard(k);
      check_val($sformatf("hazard_stall[d%0d]", k + 1), 128'(hz_o[k]), 128'(hz[k]));
      check_val($sformatf("flush_busy[d%0d]", k + 1), 128'(fb_o[k]), 128'(shadow[k] > 0));
    end
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_edge(k, hz[k]);
    #1;
    for (int k = 0; k < 3; k++)
      check_val($sformatf("ex_stage[d%0d]", k + 1), 128'(observed(k)), 128'(mdl[k]));
    @(negedge clk);
  endtask

  task automatic rand_inputs();
    in_valid = 1'($urandom_range(0, 3) != 0);
    wb_in = 2'($urandom); mem_in = 2'($urandom); ex_in = 4'($urandom);
    fnct = 6'($urandom); imm = $urandom; opA = $urandom; opB = $urandom;
    rs_addr = 5'($urandom_range(0, 3)); rt_addr = 5'($urandom_range(0, 3));
    rd_addr = 5'($urandom);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    wb_in = 2'd0; mem_in = 2'd0; ex_in = 4'd0; fnct = 6'd0; imm = 32'd0;
    opA = 32'd0; opB = 32'd0; rs_addr = 5'd0; rt_addr = 5'd0; rd_addr = 5'd0;
    for (int k = 0; k < 3; k++) begin mdl[k] = '0; shadow[k] = 0; end
    repeat (2) @(negedge clk);
    step();

    // basic load
    rst = 1'b0; in_valid = 1'b1; opA = 32'h12345678; fnct = 6'h20; wb_in = 2'b01;
    step();
    check_val("load_opA", 128'(opa_o[0]), 128'(32'h12345678));
    check_val("load_fnct", 128'(fnct_o[0]), 128'(6'h20));
    check_val("load_WB", 128'(wb_o[0]), 128'(2'b01));
    check_val("load_valid", 128'(valid_o[0]), 128'(1'b1));

    // flush pulse with a valid stream: depth 3 gives three bubbles
    flush = 1'b1; step(); flush = 1'b0;
    check_val("flush_busy_d3", 128'(fb_o[2]), 128'(1'b1));
    for (int i = 0; i < 3; i++) begin
      opA = $urandom; step();
      check_val("flush_valid_d3", 128'(valid_o[2]), 128'(i == 2));
    end

    // stall freezes everything while inputs move
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin rand_inputs(); step(); end
    stall = 1'b0; in_valid = 1'b1; step();

    // load-use hazard on rs
    mem_in = 2'b10; rt_addr = 5'd5; rs_addr = 5'd1; rd_addr = 5'd7; step();
    mem_in = 2'b00; rs_addr = 5'd5; rt_addr = 5'd2; rd_addr = 5'd9; step();
    check_val("hazard_bubble", 128'(valid_o[0]), 128'(1'b0));
    step();
    check_val("hazard_reload_rd", 128'(rd_o[0]), 128'(5'd9));

    // load to $0 never stalls
    mem_in = 2'b10; rt_addr = 5'd0; rs_addr = 5'd0; step();
    mem_in = 2'b00; step();
    check_val("zero_reg_no_bubble", 128'(valid_o[0]), 128'(1'b1));

    // flush and stall together, depth 2
    flush = 1'b1; stall = 1'b1; step(); flush = 1'b0;
    step(); step();
    check_val("flush_stall_busy_d2", 128'(fb_o[1]), 128'(1'b1));
    stall = 1'b0; step(); step();
    check_val("flush_stall_load_d2", 128'(valid_o[1]), 128'(1'b1));

    // random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      stall = 1'($urandom_range(0, 4) == 0);
      flush = 1'($urandom_range(0, 7) == 0);
      rst   = 1'($urandom_range(0, 99) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
